// File: rtl/rx_cmd_pkg.sv
// rtl/rx_cmd_pkg.sv - ASCII command constants and LED command decode helper
package rx_cmd_pkg;

  localparam logic [7:0] CMD_CLEAR = 8'h30;
  localparam logic [7:0] CMD_BASE  = 8'h31;
  localparam logic [7:0] CMD_ALL   = 8'h2A;

  typedef enum logic [1:0] {
    CMD_NONE      = 2'd0,
    CMD_TOGGLE    = 2'd1,
    CMD_CLEAR_ALL = 2'd2,
    CMD_SET_ALL   = 2'd3
  } cmd_kind_e;

  typedef struct packed {
    cmd_kind_e  kind;
    logic [3:0] idx;
  } led_cmd_t;

  // Classify one received byte; idx is only meaningful for CMD_TOGGLE.
  function automatic led_cmd_t decode_led_cmd(input logic [7:0] b, input int num_leds);
    led_cmd_t r;
    int       off;
    r.kind = CMD_NONE;
    r.idx  = '0;
    off    = int'(b) - int'(CMD_BASE);
    if (b == CMD_CLEAR) begin
      r.kind = CMD_CLEAR_ALL;
    end else if (b == CMD_ALL) begin
      r.kind = CMD_SET_ALL;
    end else if (off >= 0 && off < num_leds) begin
      r.kind = CMD_TOGGLE;
      r.idx  = off[3:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // A pop frees a slot in the same cycle, so a push at full still fits when paired with a pop.
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Head is presented combinationally; forced to zero while empty so stale entries never show.
  assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array needs no reset: contents are unreachable until written.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rx_cmd_decoder.sv
// rtl/rx_cmd_decoder.sv - ASCII LED command decoder with echo FIFO
module rx_cmd_decoder
  import rx_cmd_pkg::*;
#(
  parameter int NUM_LEDS   = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [7:0]          data,
  input  logic                ready,
  output logic [NUM_LEDS-1:0] leds,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                overflow
);

  logic [NUM_LEDS-1:0]        r_leds;
  logic                       r_overflow;
  led_cmd_t                   w_cmd;
  logic                       w_full;
  logic                       w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic                       w_pop;
  logic                       w_drop;

  assign w_cmd    = decode_led_cmd(data, NUM_LEDS);
  assign tx_valid = !w_empty;
  assign w_pop    = tx_ready && (w_count != '0);
  assign w_drop   = ready && w_full && !w_pop;
  assign leds     = r_leds;
  assign overflow = r_overflow;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_echo_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (ready),
    .i_push_data (data),
    .i_pop       (w_pop),
    .o_pop_data  (tx_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // Apply the LED action of every captured byte, even one the FIFO drops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_leds <= '0;
    end else if (ready) begin
      case (w_cmd.kind)
        CMD_TOGGLE:    r_leds <= r_leds ^ (NUM_LEDS'(1) << w_cmd.idx);
        CMD_CLEAR_ALL: r_leds <= '0;
        CMD_SET_ALL:   r_leds <= '1;
        default:       r_leds <= r_leds;
      endcase
    end
  end

  // Sticky drop flag; only reset clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// tb/tb_rx_cmd_decoder.sv - self-checking bench for rx_cmd_decoder
module tb_rx_cmd_decoder;

  localparam int NUM_LEDS   = 5;
  localparam int FIFO_DEPTH = 8;

  logic                clk;
  logic                resetn;
  logic [7:0]          data;
  logic                ready;
  logic [NUM_LEDS-1:0] leds;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                overflow;

  rx_cmd_decoder #(
    .NUM_LEDS   (NUM_LEDS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .data     (data),
    .ready    (ready),
    .leds     (leds),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  logic [NUM_LEDS-1:0] m_leds;
  logic                m_ovf;
  logic [7:0]          m_q[$];
  logic [7:0]          m_popped[$];
  logic [7:0]          dut_popped[$];

  task automatic model_reset();
    m_leds = '0;
    m_ovf  = 1'b0;
    m_q.delete();
    m_popped.delete();
    dut_popped.delete();
  endtask

  // Drive one clock cycle of inputs from a negedge, advance the model, return at the next negedge.
  task automatic tick(input logic rdy, input logic [7:0] d, input logic txr);
    bit do_pop;
    ready    = rdy;
    data     = d;
    tx_ready = txr;
    if (tx_valid && tx_ready) dut_popped.push_back(tx_data);
    do_pop = txr && (m_q.size() > 0);
    if (rdy) begin
      if (d == 8'h30)
        m_leds = '0;
      else if (d == 8'h2A)
        m_leds = '1;
      else if (int'(d) >= 'h31 && int'(d) < 'h31 + NUM_LEDS)
        m_leds = m_leds ^ NUM_LEDS'(1 << (int'(d) - 'h31));
    end
    if (do_pop) m_popped.push_back(m_q.pop_front());
    if (rdy) begin
      if (m_q.size() < FIFO_DEPTH) m_q.push_back(d);
      else m_ovf = 1'b1;
    end
    @(negedge clk);
    ready    = 1'b0;
    tx_ready = 1'b0;
  endtask

  task automatic apply_reset();
    ready    = 1'b0;
    tx_ready = 1'b0;
    data     = 8'h00;
    resetn   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++;
    if ({leds, tx_valid, tx_data, overflow} !== '0)
      $display("FAIL reset_state: got leds=%b valid=%b data=%h ovf=%b, want all zero", leds, tx_valid, tx_data, overflow);
    else n_pass++;
  endtask

  task automatic test_led_toggle();
    logic [NUM_LEDS-1:0] want;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 8'(8'h31 + i), 1'b1);
      want = NUM_LEDS'((1 << (i + 1)) - 1);
      n_total++;
      if (leds !== want) $display("FAIL toggle_leds[%0d]: got %b want %b", i, leds, want);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1);
    n_total++;
    if (dut_popped.size() !== 5) $display("FAIL toggle_echo_len: got %0d want 5", dut_popped.size());
    else n_pass++;
    for (int i = 0; i < dut_popped.size() && i < 5; i++) begin
      n_total++;
      if (dut_popped[i] !== 8'(8'h31 + i)) $display("FAIL toggle_echo[%0d]: got %h want %h", i, dut_popped[i], 8'(8'h31 + i));
      else n_pass++;
    end
    n_total++;
    if (overflow !== 1'b0) $display("FAIL toggle_ovf: got %b want 0", overflow);
    else n_pass++;
  endtask

  task automatic test_commands();
    for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h31 + i), 1'b1);
    n_total++;
    if (leds !== 5'b00000) $display("FAIL cmd_retoggle: got %b want 00000", leds);
    else n_pass++;
    tick(1'b1, 8'h2A, 1'b1);
    n_total++;
    if (leds !== 5'b11111) $display("FAIL cmd_all: got %b want 11111", leds);
    else n_pass++;
    tick(1'b1, 8'h30, 1'b1);
    n_total++;
    if (leds !== 5'b00000) $display("FAIL cmd_clear: got %b want 00000", leds);
    else n_pass++;
    tick(1'b1, 8'h41, 1'b1);
    n_total++;
    if (leds !== 5'b00000) $display("FAIL cmd_other: got %b want 00000", leds);
    else n_pass++;
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1);
    n_total++;
    if (dut_popped.size() == 0 || dut_popped[dut_popped.size()-1] !== 8'h41)
      $display("FAIL cmd_echo_last: got %h want 41", dut_popped.size() ? dut_popped[dut_popped.size()-1] : 8'hxx);
    else n_pass++;
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 8'(8'h61 + i), 1'b0);
      if (i == 0) begin
        n_total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h61) $display("FAIL ovf_first: got valid=%b data=%h want 1/61", tx_valid, tx_data);
        else n_pass++;
      end
      if (i == 7) begin
        n_total++;
        if (overflow !== 1'b0) $display("FAIL ovf_early: got %b want 0 after 8 bytes", overflow);
        else n_pass++;
      end
      if (i == 8) begin
        n_total++;
        if (overflow !== 1'b1) $display("FAIL ovf_rise: got %b want 1 after 9 bytes", overflow);
        else n_pass++;
      end
    end
    for (int i = 0; i < 10; i++) tick(1'b0, 8'h00, 1'b1);
    n_total++;
    if (dut_popped.size() !== 8) $display("FAIL ovf_drain_len: got %0d want 8", dut_popped.size());
    else n_pass++;
    for (int i = 0; i < dut_popped.size() && i < 8; i++) begin
      n_total++;
      if (dut_popped[i] !== 8'(8'h61 + i)) $display("FAIL ovf_drain[%0d]: got %h want %h", i, dut_popped[i], 8'(8'h61 + i));
      else n_pass++;
    end
    n_total++;
    if (tx_valid !== 1'b0 || overflow !== 1'b1) $display("FAIL ovf_after: got valid=%b ovf=%b want 0/1", tx_valid, overflow);
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] want[$];
    apply_reset();
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      want.push_back(8'(8'h80 + i));
      tick(1'b1, 8'(8'h80 + i), 1'b0);
    end
    tick(1'b1, 8'h77, 1'b1);
    void'(want.pop_front());
    want.push_back(8'h77);
    n_total++;
    if (dut_popped.size() !== 1 || dut_popped[0] !== 8'h80) $display("FAIL full_pp_pop: got n=%0d want head 80 popped", dut_popped.size());
    else n_pass++;
    n_total++;
    if (overflow !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h81)
      $display("FAIL full_pp_state: got ovf=%b valid=%b data=%h want 0/1/81", overflow, tx_valid, tx_data);
    else n_pass++;
    dut_popped.delete();
    for (int i = 0; i < FIFO_DEPTH + 2; i++) tick(1'b0, 8'h00, 1'b1);
    n_total++;
    if (dut_popped.size() !== FIFO_DEPTH) $display("FAIL full_pp_count: got %0d want %0d", dut_popped.size(), FIFO_DEPTH);
    else n_pass++;
    for (int i = 0; i < dut_popped.size() && i < FIFO_DEPTH; i++) begin
      n_total++;
      if (dut_popped[i] !== want[i]) $display("FAIL full_pp_order[%0d]: got %h want %h", i, dut_popped[i], want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_empty_push_pop();
    apply_reset();
    tick(1'b1, 8'h33, 1'b1);
    n_total++;
    if (dut_popped.size() !== 0) $display("FAIL empty_pp_nopop: got %0d pops want 0", dut_popped.size());
    else n_pass++;
    n_total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h33 || leds !== 5'b00100)
      $display("FAIL empty_pp_state: got valid=%b data=%h leds=%b want 1/33/00100", tx_valid, tx_data, leds);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    tick(1'b1, 8'h31, 1'b0);
    tick(1'b1, 8'h32, 1'b0);
    tick(1'b1, 8'h78, 1'b0);
    #2 resetn = 1'b0;
    #1;
    n_total++;
    if (tx_valid !== 1'b0 || leds !== '0 || overflow !== 1'b0 || tx_data !== 8'h00)
      $display("FAIL async_reset: got valid=%b leds=%b ovf=%b data=%h want 0", tx_valid, leds, overflow, tx_data);
    else n_pass++;
    #1 resetn = 1'b1;
    model_reset();
    @(negedge clk);
    tick(1'b0, 8'h00, 1'b1);
    n_total++;
    if (tx_valid !== 1'b0 || dut_popped.size() !== 0)
      $display("FAIL async_reset_empty: got valid=%b pops=%0d want 0/0", tx_valid, dut_popped.size());
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       r;
    logic       t;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 1) == 1);
      t = ($urandom_range(0, 9) < 4);
      case ($urandom_range(0, 3))
        0:       d = 8'(8'h30 + $urandom_range(0, 6));
        1:       d = 8'h2A;
        2:       d = 8'($urandom);
        default: d = 8'(8'h31 + $urandom_range(0, NUM_LEDS - 1));
      endcase
      tick(r, d, t);
      n_total++;
      if (leds !== m_leds || overflow !== m_ovf || tx_valid !== (m_q.size() > 0) ||
          tx_data !== ((m_q.size() > 0) ? m_q[0] : 8'h00))
        $display("FAIL random[%0d]: got leds=%b ovf=%b valid=%b data=%h want leds=%b ovf=%b n=%0d head=%h",
                 c, leds, overflow, tx_valid, tx_data, m_leds, m_ovf, m_q.size(), (m_q.size() > 0) ? m_q[0] : 8'h00);
      else n_pass++;
    end
    for (int i = 0; i < FIFO_DEPTH + 2; i++) tick(1'b0, 8'h00, 1'b1);
    n_total++;
    if (dut_popped != m_popped) $display("FAIL random_echo: got %0d bytes want %0d, or order differs", dut_popped.size(), m_popped.size());
    else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_pass   = 0;
    n_total  = 0;
    resetn   = 1'b0;
    ready    = 1'b0;
    tx_ready = 1'b0;
    data     = 8'h00;
    model_reset();
    @(negedge clk);
    test_reset();
    test_led_toggle();
    test_commands();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rx_cmd_decoder.md
# rx_cmd_decoder

- Sits directly downstream of the RS-232 receiver: consumes its `data`/`ready` byte stream.
- Decodes single-character ASCII LED commands and drives the board LEDs.
- Buffers every received byte in a small first-word-fall-through FIFO, which feeds the echo transmitter over a valid/ready handshake.

## Interface

Parameters:
- `NUM_LEDS`, default 5: number of LEDs, 1..9.
- `FIFO_DEPTH`, default 8: echo FIFO entries; power of two, ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, 12 MHz.
- `resetn`  in  1  asynchronous active-low reset.
- `data`  in  8  received byte; valid only in the cycle `ready`=1.
- `ready`  in  1  single-cycle strobe from the receiver.
- `leds`  out  NUM_LEDS  LED state, bit i = LED i+1.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  transmitter accepts `tx_data` this cycle.
- `overflow`  out  1  sticky: a byte was dropped on a full FIFO.

## Operation

- Reset (async assert, sync-to-`clk` deassert use): `leds`=0, `tx_valid`=0, `tx_data`=0, `overflow`=0, FIFO pointers and count = 0.
- Byte capture happens only in a cycle with `ready`=1. `ready` held high for k cycles means k bytes.
- Command decode on the captured byte:
  - ASCII `'1'`..`'0'+NUM_LEDS` (0x31..): toggle `leds[byte-0x31]`.
  - `'0'` (0x30): clear all LEDs.
  - `'*'` (0x2A): set all LEDs.
  - Any other byte: no LED change.
- Echo: every captured byte, command or not, is pushed to the FIFO.
- Push when count==FIFO_DEPTH and no pop in the same cycle:
  - the byte is dropped and `overflow` is set;
  - the LED action is still applied.
- `overflow` clears only on reset.
- Pop: the cycle `tx_valid && tx_ready`, the read pointer advances. `tx_ready` while empty is ignored.
- Simultaneous push and pop:
  - Count unchanged, both accepted.
  - Holds even at full (no overflow) and at empty+push (no pop happens, since `tx_valid`=0).
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.

## Timing

- LED latency: `leds` updates on the clock edge that samples `ready`=1, so it is visible in the next cycle.
- Echo latency:
  - Push into an empty FIFO: `tx_valid`=1 and `tx_data` = the byte in the next cycle.
  - FWFT: `tx_data` always equals the head entry while `tx_valid`=1.
- After a pop, the next head (or `tx_valid`=0) is presented the following cycle. No bubble cycles: back-to-back pops are allowed every cycle.
- `tx_data` and `tx_valid` are stable while `tx_valid`=1 and `tx_ready`=0.
- Reset mid-operation: everything returns to reset values immediately. FIFO contents are discarded; no partial echo.
- Throughput requirement: sustains one byte per cycle on both sides. Receiver rate (one byte per ~12 500 cycles at 9600 baud) is far below this.

## Structure

- Package `rx_cmd_pkg`: ASCII constants `CMD_CLEAR`=0x30, `CMD_BASE`=0x31, `CMD_ALL`=0x2A; a function returning the LED index / valid flag for a byte.
- Sub-module `sync_fifo` (parameterised width/depth, FWFT, push/pop/full/empty/count) holds the echo buffer.
- The top holds the decode logic and the `leds` and `overflow` registers.

## Test plan

- Reset, then bytes "1","2","3","4","5" one at a time with `tx_ready`=1 → `leds` goes 00001→00011→00111→01111→11111; the echo stream is 0x31..0x35 in order; `overflow`=0.
- The same five bytes again → `leds` returns to 00000; "*" → 11111; "0" → 00000; "A" (0x41) → `leds` unchanged, 0x41 echoed.
- Hold `tx_ready`=0 and send 10 bytes 0x61..0x6A with FIFO_DEPTH=8:
  - `tx_valid`=1 after the first byte; `overflow` rises on the 9th byte.
  - Release `tx_ready` → exactly 0x61..0x68 are popped, then `tx_valid`=0.
- FIFO full, `ready` pulse and `tx_ready`=1 in the same cycle → head popped, new byte appended last, `overflow` stays 0, count stays 8.
- Empty FIFO, `ready` with 0x33 and `tx_ready`=1 in the same cycle → no pop; next cycle `tx_valid`=1, `tx_data`=0x33.
- Three bytes queued, assert `resetn`=0 asynchronously between clock edges → `tx_valid`, `leds` and `overflow` are 0 before the next edge. After release, the FIFO is empty.
